nand_gate: RTL and testbench
============================

# nand_gate

Two-input NAND cell with a combinational result, a registered copy, and a saturating transition counter. Serves as the basic logic primitive in the gate-level teaching library and as a reference cell for checking clocked benches. The combinational path is the primary function. The registered output and counter let a clocked bench observe the result and its activity.

## Interface
- `WIDTH`, default 1: number of independent NAND lanes (bitwise).
- `CNT_W`, default 16: width of the transition counter.

- `clk`  input  1: single clock; all state updates on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `a`  input  WIDTH: first operand.
- `b`  input  WIDTH: second operand.
- `clr`  input  1: synchronous clear of the counter.
- `c`  output  WIDTH: combinational NAND, `c = ~(a & b)`.
- `c_q`  output  WIDTH: `c` registered once.
- `c_chg`  output  1: registered pulse; high for one cycle when `c_q` changed on the previous edge.
- `chg_cnt`  output  CNT_W: saturating count of edges on which `c_q` changed.

## Operation
- `c` is purely combinational, per lane. `c[i]` is 0 only when `a[i]=1` and `b[i]=1`; otherwise it is 1.
- No X-propagation masking: X on an input gives X on `c` through normal operator semantics.
- `c_q` captures `c` on every rising edge. There is no enable.
- Change detection: `chg_next = |(c ^ c_q)`.
  - On each edge, `c_chg <= chg_next`.
  - If `clr` is low and `chg_next` is high, `chg_cnt` increments.
- `chg_cnt` saturates at `2^CNT_W - 1`. It never wraps.
- `clr` is high: `chg_cnt <= 0` on that edge. `clr` takes priority over a simultaneous change, so that change is not counted. `c_q` and `c_chg` update normally regardless of `clr`.
- Multiple lanes changing on the same edge count as one event.

## Timing
- Reset values while `rst_n=0`, applied immediately and asynchronously:
  - `c_q` = all ones, consistent with `a=b=0`.
  - `c_chg` = 0.
  - `chg_cnt` = 0.
  - `c` is unaffected by reset and keeps following its inputs.
- `rst_n` deasserts: normal operation starts at the first following rising edge.
- Reset asserted mid-operation: registered state is lost immediately. No pending change is counted.
- Latency:
  - `c`: 0 cycles, combinational.
  - `c_q`: 1 cycle.
  - `c_chg` and the `chg_cnt` update: visible 1 cycle after the input change. They are computed from `c` versus `c_q` at the same edge that loads `c_q`.
- Inputs that change and return between two edges produce no count. Only sampled values matter.

## Structure
- Package `nand_gate_pkg`:
  - default constants `NAND_WIDTH_DEF=1` and `NAND_CNT_W_DEF=16`;
  - function `sat_inc(cnt)` returning the saturating increment.
- One sub-module is natural: `nand_lane`. It holds the combinational NAND and the registered bit for one lane and is instantiated `WIDTH` times via generate.
- Change detection, the pulse, and the counter live in the top module.

## Test plan
- Truth table at `WIDTH=1`: apply a,b = 00, 01, 10, 11, each held 100 ns.
  - Required `c`: 1, 1, 1, 0, immediately.
  - Required `c_q`: the same sequence, one clock later.
- Reset: hold `rst_n=0` with a=b=1.
  - `c` = 0 and `c_q` = 1 throughout.
  - `chg_cnt` = 0 and `c_chg` = 0.
  - After release, with a=b=1 held, `c_chg` pulses once and `chg_cnt` = 1.
- Counting: toggle a=b between 11 and 00 on each of 5 clocks.
  - `chg_cnt` = 5.
  - `c_chg` is high on each of those 5 cycles.
- Clear priority: assert `clr` on the same edge as a change.
  - `chg_cnt` = 0 afterwards.
  - `c_chg` = 1 and `c_q` is updated.
- Saturation: `CNT_W=3`, 10 changes, `chg_cnt` = 7.
- Multi-lane, `WIDTH=4`: a=4'b1100, b=4'b1010.
  - `c` = 4'b0111.
  - Changing two lanes on one edge increments `chg_cnt` by exactly 1.

Source files
------------

// File: rtl/nand_gate_pkg.sv
// -----------------------------------------------------------------------------
// nand_gate_pkg
// Shared constants and helpers for the nand_gate cell.
//   NAND_WIDTH_DEF : default number of independent NAND lanes
//   NAND_CNT_W_DEF : default width of the transition counter
//   NAND_CNT_W_MAX : widest counter sat_inc can handle
//   sat_inc()      : saturating increment of a counter of a given width
// -----------------------------------------------------------------------------
package nand_gate_pkg;

    localparam int NAND_WIDTH_DEF = 1;
    localparam int NAND_CNT_W_DEF = 16;
    localparam int NAND_CNT_W_MAX = 64;

    // Counters are carried in a 64-bit container so one function serves every
    // CNT_W. The ceiling is 2^cnt_w - 1; for cnt_w = 64 the shift yields 0 and
    // the subtraction wraps to all ones, which is still the right ceiling.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] cnt,
        input int unsigned cnt_w = NAND_CNT_W_DEF
    );
        logic [63:0] max_v;
        max_v = (64'd1 << cnt_w) - 64'd1;
        if (cnt >= max_v) begin
            return max_v;
        end
        return cnt + 64'd1;
    endfunction

endpackage : nand_gate_pkg

// File: rtl/nand_gate_lane.sv
// -----------------------------------------------------------------------------
// nand_lane
// One NAND lane: combinational result plus a registered copy.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (registered copy goes to 1)
//   i_a     : first operand
//   i_b     : second operand
//   o_c     : ~(i_a & i_b), combinational
//   o_c_q   : o_c registered once
// -----------------------------------------------------------------------------
module nand_lane (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_a,
    input  logic i_b,
    output logic o_c,
    output logic o_c_q
);

    logic w_c;
    logic r_c_q;

    // Plain operator semantics so an X on an input shows up as X here.
    assign w_c = ~(i_a & i_b);

    // Reset value 1 matches the NAND of a=b=0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_q <= 1'b1;
        end else begin
            r_c_q <= w_c;
        end
    end

    assign o_c   = w_c;
    assign o_c_q = r_c_q;

endmodule : nand_lane

// File: rtl/nand_gate.sv
// -----------------------------------------------------------------------------
// nand_gate
// WIDTH-lane bitwise NAND with a registered copy, a one-cycle change pulse and
// a saturating count of edges on which the registered copy changed.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   a, b    : operands, WIDTH bits
//   clr     : synchronous counter clear (wins over a simultaneous change)
//   c       : ~(a & b), combinational
//   c_q     : c registered once
//   c_chg   : high for one cycle after an edge on which c_q changed
//   chg_cnt : saturating count of such edges, CNT_W bits
// -----------------------------------------------------------------------------
module nand_gate
    import nand_gate_pkg::*;
#(
    parameter int WIDTH = NAND_WIDTH_DEF,
    parameter int CNT_W = NAND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             c_chg,
    output logic [CNT_W-1:0] chg_cnt
);

    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_c_q;
    logic             w_chg_next;
    logic             r_c_chg;
    logic [CNT_W-1:0] r_chg_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            nand_lane u_lane (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_a     (a[gi]),
                .i_b     (b[gi]),
                .o_c     (w_c[gi]),
                .o_c_q   (w_c_q[gi])
            );
        end
    endgenerate

    // Compared against the value c_q is about to be loaded with, so the pulse
    // and count land in the same cycle as the new c_q. Any number of lanes
    // differing collapses to a single event.
    assign w_chg_next = |(w_c ^ w_c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_chg   <= 1'b0;
            r_chg_cnt <= '0;
        end else begin
            r_c_chg <= w_chg_next;
            if (clr) begin
                r_chg_cnt <= '0;
            end else if (w_chg_next) begin
                r_chg_cnt <= CNT_W'(sat_inc(64'(r_chg_cnt), CNT_W));
            end
        end
    end

    assign c       = w_c;
    assign c_q     = w_c_q;
    assign c_chg   = r_c_chg;
    assign chg_cnt = r_chg_cnt;

endmodule : nand_gate

// File: tb/tb_nand_gate.sv
// -----------------------------------------------------------------------------
// tb_nand_gate
// Two instances share clock and reset: a 1-lane/16-bit-counter cell and a
// 4-lane/3-bit-counter cell. The driver applies inputs on falling edges and
// queues the expected post-edge outputs of both cells; the monitor pops one
// entry each rising edge (+1) and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nand_gate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
    logic [3:0]  a4 = 4'b0, b4 = 4'b0;
    logic        clr4 = 1'b0;
    logic        c1, q1, chg1;
    logic [15:0] cnt1;
    logic [3:0]  c4, q4;
    logic        chg4;
    logic [2:0]  cnt4;

    always #5 clk = ~clk;

    nand_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr1),
        .c(c1), .c_q(q1), .c_chg(chg1), .chg_cnt(cnt1)
    );

    nand_gate #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr4),
        .c(c4), .c_q(q4), .c_chg(chg4), .chg_cnt(cnt4)
    );

    typedef struct {
        logic [0:0]  c1;
        logic [0:0]  q1;
        logic [0:0]  chg1;
        logic [15:0] cnt1;
        logic [3:0]  c4;
        logic [3:0]  q4;
        logic [0:0]  chg4;
        logic [2:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: last sampled result and an event count.
    logic        m1_q = 1'b1;
    int          m1_cnt = 0;
    logic [3:0]  m4_q = 4'hF;
    int          m4_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Apply one cycle of stimulus and queue what both cells should show
    // after the coming rising edge.
    task automatic step(input logic ia1, input logic ib1, input logic iclr1,
                        input logic [3:0] ia4, input logic [3:0] ib4,
                        input logic iclr4, input logic irst_n);
        exp_t e;
        @(negedge clk);
        rst_n = irst_n;
        a1 = ia1; b1 = ib1; clr1 = iclr1;
        a4 = ia4; b4 = ib4; clr4 = iclr4;

        e.c1 = ~(ia1 & ib1);
        e.c4 = ~(ia4 & ib4);
        if (!irst_n) begin
            m1_q = 1'b1; m1_cnt = 0; e.chg1 = 1'b0;
            m4_q = 4'hF; m4_cnt = 0; e.chg4 = 1'b0;
        end else begin
            e.chg1 = (e.c1 != m1_q);
            m1_q = e.c1;
            if (iclr1) m1_cnt = 0;
            else if (e.chg1 && m1_cnt < 65535) m1_cnt++;

            e.chg4 = (e.c4 != m4_q);
            m4_q = e.c4;
            if (iclr4) m4_cnt = 0;
            else if (e.chg4 && m4_cnt < 7) m4_cnt++;
        end
        e.q1 = m1_q; e.cnt1 = 16'(m1_cnt);
        e.q4 = m4_q; e.cnt4 = 3'(m4_cnt);
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge while the queue has data.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("c1",    32'(c1),   32'(e.c1));
                chk("c_q1",  32'(q1),   32'(e.q1));
                chk("c_chg1",32'(chg1), 32'(e.chg1));
                chk("cnt1",  32'(cnt1), 32'(e.cnt1));
                chk("c4",    32'(c4),   32'(e.c4));
                chk("c_q4",  32'(q4),   32'(e.q4));
                chk("c_chg4",32'(chg4), 32'(e.chg4));
                chk("cnt4",  32'(cnt4), 32'(e.cnt4));
            end
        end
    end

    localparam logic [3:0] A4_P = 4'b1100;
    localparam logic [3:0] B4_P = 4'b1010;   // c4 = 0111
    localparam logic [3:0] AB4_Q = 4'b1110;  // c4 = 0001: two lanes differ from 0111

    initial begin
        logic [3:0] ra4, rb4;
        // Reset held with a=b=1: c=0 while c_q stays 1.
        for (int i = 0; i < 3; i++) step(1, 1, 0, A4_P, B4_P, 0, 0);
        // Release: the first edge sees a change on both cells.
        for (int i = 0; i < 3; i++) step(1, 1, 0, A4_P, B4_P, 0, 1);

        // Truth table, each row held 100 ns. Meanwhile the 4-lane cell is
        // cleared, then toggled between two-lane-different patterns 10 times.
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 10; j++) begin
                int k;
                logic [1:0] ab;
                k = t * 10 + j;
                ab = 2'(t);
                if (k >= 1 && k <= 10 && (k % 2) == 1)
                    step(ab[1], ab[0], 0, AB4_Q, AB4_Q, 0, 1);
                else
                    step(ab[1], ab[0], 0, A4_P, B4_P, (k == 0), 1);
            end
        end

        // Clear, then five toggles of a=b between 00 and 11.
        step(1, 1, 1, A4_P, B4_P, 0, 1);
        for (int i = 0; i < 5; i++) step(i % 2, i % 2, 0, A4_P, B4_P, 0, 1);

        // Clear on the same edge as a change.
        step(1, 1, 1, A4_P, B4_P, 0, 1);

        // Build up some state, then reset on a changing cycle.
        step(0, 1, 0, AB4_Q, AB4_Q, 0, 1);
        step(1, 1, 0, A4_P, B4_P, 0, 1);
        step(0, 0, 0, AB4_Q, AB4_Q, 0, 0);
        #1;
        chk("async_rst_q1",   32'(q1),   32'h1);
        chk("async_rst_cnt1", 32'(cnt1), 32'h0);
        chk("async_rst_q4",   32'(q4),   32'hF);
        chk("async_rst_cnt4", 32'(cnt4), 32'h0);
        step(0, 0, 0, AB4_Q, AB4_Q, 0, 1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 300; i++) begin
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                 ra4, rb4, ($urandom_range(0, 15) == 0), 1);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #5;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_nand_gate
